sram_port_arbiter: RTL and testbench

Shares one single-port 64-bit synchronous SRAM between the core's instruction-fetch port and data port. The arbiter sits between the core's two SRAM request interfaces and the physical memory.

- Data has fixed priority.
- A starvation counter forces an instruction grant after a bounded run of data grants.
- Read data is returned one cycle after grant, with an rvalid strobe and the correct lane selected per requester.

---
 rtl/sram_port_arbiter_if.sv | 42 ++++
 rtl/sram_port_arbiter.sv | 92 +++++++++
 tb/tb_sram_port_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - core-side request/response and memory-side signals of the SRAM port arbiter
interface sram_port_arbiter_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_gnt;
   logic        inst_rvalid;
   logic [31:0] inst_rdata;

   logic        data_req;
   logic [7:0]  data_wen;
   logic [31:0] data_addr;
   logic [63:0] data_wdata;
   logic        data_gnt;
   logic        data_rvalid;
   logic [63:0] data_rdata;

   logic        mem_en;
   logic [7:0]  mem_wen;
   logic [31:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;

   // Arbiter side
   modport slave (
      input  inst_req, inst_addr,
      output inst_gnt, inst_rvalid, inst_rdata,
      input  data_req, data_wen, data_addr, data_wdata,
      output data_gnt, data_rvalid, data_rdata,
      output mem_en, mem_wen, mem_addr, mem_wdata,
      input  mem_rdata
   );

   // Core requesters and physical memory side
   modport master (
      output inst_req, inst_addr,
      input  inst_gnt, inst_rvalid, inst_rdata,
      output data_req, data_wen, data_addr, data_wdata,
      input  data_gnt, data_rvalid, data_rdata,
      input  mem_en, mem_wen, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - fixed-priority data/instruction arbiter for one 64-bit single-port SRAM
module sram_port_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clock,
   input  logic                reset_n,
   sram_port_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      RESP_NONE = 2'd0,
      RESP_INST = 2'd1,
      RESP_DATA = 2'd2
   } resp_owner_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   resp_owner_t resp_owner;
   logic        resp_hi;
   logic [3:0]  streak;
   logic        inst_gnt;
   logic        data_gnt;

   // Low address bits select bytes inside the word; the arbiter never looks at them
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.inst_addr[1:0], bus.data_addr[2:0]};

   // Grant decision: data wins unless the instruction side has waited STARVE_LIMIT grants
   always_comb begin
      inst_gnt = 1'b0;
      data_gnt = 1'b0;
      if (reset_n) begin
         if (bus.data_req && (!bus.inst_req || (streak < LIMIT))) begin
            data_gnt = 1'b1;
         end else if (bus.inst_req) begin
            inst_gnt = 1'b1;
         end
      end
   end

   assign bus.inst_gnt = inst_gnt;
   assign bus.data_gnt = data_gnt;

   // Drive the memory from whichever requester is granted this cycle; idle bus is all zeros
   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_wen   = 8'h00;
      bus.mem_addr  = 32'h0;
      bus.mem_wdata = 64'h0;
      if (data_gnt) begin
         bus.mem_en    = 1'b1;
         bus.mem_wen   = bus.data_wen;
         bus.mem_addr  = {bus.data_addr[31:3], 3'b000};
         bus.mem_wdata = bus.data_wdata;
      end else if (inst_gnt) begin
         bus.mem_en    = 1'b1;
         bus.mem_addr  = {bus.inst_addr[31:3], 3'b000};
      end
   end

   // Remember who owns the access in flight and which instruction lane it wants
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         resp_owner <= RESP_NONE;
         resp_hi    <= 1'b0;
      end else if (inst_gnt) begin
         resp_owner <= RESP_INST;
         resp_hi    <= bus.inst_addr[2];
      end else if (data_gnt) begin
         resp_owner <= RESP_DATA;
      end else begin
         resp_owner <= RESP_NONE;
      end
   end

   // Count data grants taken while an instruction fetch waits; saturates at the limit
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         streak <= 4'd0;
      end else if (!bus.inst_req || inst_gnt) begin
         streak <= 4'd0;
      end else if (data_gnt && (streak < LIMIT)) begin
         streak <= streak + 4'd1;
      end
   end

   assign bus.inst_rvalid = (resp_owner == RESP_INST);
   assign bus.data_rvalid = (resp_owner == RESP_DATA);
   assign bus.inst_rdata  = resp_hi ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
   assign bus.data_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - scoreboard bench for sram_port_arbiter with a behavioural SRAM
module tb_sram_port_arbiter;

   typedef struct {
      bit          is_inst;
      bit          chk;
      logic [63:0] data;
      int          due;
   } exp_t;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   passed = 0;
   int   total = 0;
   int   cyc = 0;
   exp_t sb[$];
   logic [63:0] mem [0:63];

   sram_port_arbiter_if bus();

   sram_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Behavioural synchronous single-port SRAM with byte enables
   always @(posedge clock) begin
      if (bus.mem_en) begin
         if (bus.mem_wen == 8'h00) begin
            bus.mem_rdata <= mem[bus.mem_addr[8:3]];
         end else begin
            for (int b = 0; b < 8; b++) begin
               if (bus.mem_wen[b]) mem[bus.mem_addr[8:3]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
         end
      end
   end

   // Scoreboard: every rvalid must match the oldest expected response, on its due cycle
   always @(negedge clock) begin
      exp_t e;
      if (bus.inst_rvalid || bus.data_rvalid) begin
         total++;
         if (sb.size() == 0) begin
            $display("FAIL resp_unexpected inst_rvalid=%b data_rvalid=%b cyc=%0d required no response", bus.inst_rvalid, bus.data_rvalid, cyc);
         end else begin
            e = sb.pop_front();
            if (bus.inst_rvalid && bus.data_rvalid) begin
               $display("FAIL resp_both inst_rvalid=1 data_rvalid=1 required exactly one");
            end else if (e.due != cyc) begin
               $display("FAIL resp_latency cyc=%0d required cyc=%0d", cyc, e.due);
            end else if (bus.inst_rvalid !== e.is_inst) begin
               $display("FAIL resp_owner inst_rvalid=%b required %b", bus.inst_rvalid, e.is_inst);
            end else if (e.chk && e.is_inst && (bus.inst_rdata !== e.data[31:0])) begin
               $display("FAIL inst_rdata got %h required %h", bus.inst_rdata, e.data[31:0]);
            end else if (e.chk && !e.is_inst && (bus.data_rdata !== e.data)) begin
               $display("FAIL data_rdata got %h required %h", bus.data_rdata, e.data);
            end else begin
               passed++;
            end
         end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
         total++;
         e = sb.pop_front();
         $display("FAIL resp_missing cyc=%0d no rvalid, required %s response due cyc=%0d", cyc, e.is_inst ? "inst" : "data", e.due);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_all();
      bus.inst_req   = 1'b0;
      bus.inst_addr  = 32'h0;
      bus.data_req   = 1'b0;
      bus.data_wen   = 8'h00;
      bus.data_addr  = 32'h0;
      bus.data_wdata = 64'h0;
   endtask

   task automatic push_exp(input bit is_inst, input bit chk, input logic [63:0] data);
      exp_t e;
      e.is_inst = is_inst;
      e.chk     = chk;
      e.data    = data;
      e.due     = cyc + 1;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      bus.inst_req   = 1'b1;
      bus.inst_addr  = 32'h0000_0204;
      bus.data_req   = 1'b1;
      bus.data_wen   = 8'hFF;
      bus.data_addr  = 32'h0000_0108;
      bus.data_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      repeat (2) @(posedge clock);
      @(negedge clock);
      total++;
      if ({bus.inst_gnt, bus.data_gnt} !== 2'b00) $display("FAIL reset_gnt got %b required 00", {bus.inst_gnt, bus.data_gnt});
      else passed++;
      total++;
      if ({bus.inst_rvalid, bus.data_rvalid} !== 2'b00) $display("FAIL reset_rvalid got %b required 00", {bus.inst_rvalid, bus.data_rvalid});
      else passed++;
      total++;
      if (bus.mem_en !== 1'b0 || bus.mem_wen !== 8'h00) $display("FAIL reset_mem_en got en=%b wen=%h required 0/00", bus.mem_en, bus.mem_wen);
      else passed++;
      total++;
      if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 64'h0) $display("FAIL reset_mem_bus got addr=%h wdata=%h required 0", bus.mem_addr, bus.mem_wdata);
      else passed++;
      total++;
      if (dut.streak !== 4'd0) $display("FAIL reset_streak got %0d required 0", dut.streak);
      else passed++;
      idle_all();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_write_read();
      bus.data_req   = 1'b1;
      bus.data_wen   = 8'hFF;
      bus.data_addr  = 32'h0000_0100;
      bus.data_wdata = 64'h1122_3344_5566_7788;
      @(negedge clock);
      total++;
      if (bus.data_gnt !== 1'b1 || bus.inst_gnt !== 1'b0) $display("FAIL wr_gnt got data=%b inst=%b required 1/0", bus.data_gnt, bus.inst_gnt);
      else passed++;
      total++;
      if (bus.mem_en !== 1'b1 || bus.mem_wen !== 8'hFF || bus.mem_addr !== 32'h100 || bus.mem_wdata !== 64'h1122_3344_5566_7788)
         $display("FAIL wr_mem got en=%b wen=%h addr=%h wdata=%h required 1/ff/00000100/1122334455667788", bus.mem_en, bus.mem_wen, bus.mem_addr, bus.mem_wdata);
      else passed++;
      push_exp(1'b0, 1'b0, 64'h0);
      tick();
      bus.data_wen   = 8'h00;
      bus.data_addr  = 32'h0000_0105;
      bus.data_wdata = 64'h0;
      @(negedge clock);
      total++;
      if (bus.data_gnt !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_wen !== 8'h00)
         $display("FAIL rd_mem got gnt=%b addr=%h wen=%h required 1/00000100/00", bus.data_gnt, bus.mem_addr, bus.mem_wen);
      else passed++;
      push_exp(1'b0, 1'b1, 64'h1122_3344_5566_7788);
      tick();
      idle_all();
      @(negedge clock);
      total++;
      if (bus.mem_en !== 1'b0 || bus.mem_addr !== 32'h0) $display("FAIL idle_mem got en=%b addr=%h required 0/0", bus.mem_en, bus.mem_addr);
      else passed++;
      tick();
   endtask

   task automatic test_inst_lane();
      bus.inst_req  = 1'b1;
      bus.inst_addr = 32'h0000_0104;
      @(negedge clock);
      total++;
      if (bus.inst_gnt !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_wen !== 8'h00 || bus.mem_wdata !== 64'h0)
         $display("FAIL inst_hi_mem got gnt=%b addr=%h wen=%h wdata=%h required 1/00000100/00/0", bus.inst_gnt, bus.mem_addr, bus.mem_wen, bus.mem_wdata);
      else passed++;
      push_exp(1'b1, 1'b1, 64'h1122_3344);
      tick();
      bus.inst_addr = 32'h0000_0103;
      @(negedge clock);
      total++;
      if (bus.inst_gnt !== 1'b1 || bus.mem_addr !== 32'h100)
         $display("FAIL inst_lo_mem got gnt=%b addr=%h required 1/00000100", bus.inst_gnt, bus.mem_addr);
      else passed++;
      push_exp(1'b1, 1'b1, 64'h5566_7788);
      tick();
      idle_all();
      tick();
   endtask

   task automatic test_starvation();
      bit exp_inst;
      bus.inst_req  = 1'b1;
      bus.inst_addr = 32'h0000_0100;
      bus.data_req  = 1'b1;
      bus.data_wen  = 8'h00;
      bus.data_addr = 32'h0000_0100;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         exp_inst = ((i % 5) == 4);
         total++;
         if (bus.inst_gnt !== exp_inst || bus.data_gnt !== !exp_inst)
            $display("FAIL starve_gnt[%0d] got inst=%b data=%b required inst=%b data=%b", i, bus.inst_gnt, bus.data_gnt, exp_inst, !exp_inst);
         else passed++;
         if (exp_inst) push_exp(1'b1, 1'b1, 64'h5566_7788);
         else          push_exp(1'b0, 1'b1, 64'h1122_3344_5566_7788);
         tick();
      end
      idle_all();
      tick();
   endtask

   task automatic test_back_to_back();
      bit is_inst;
      logic [31:0] a;
      for (int i = 0; i < 8; i++) begin
         is_inst = ((i % 2) == 0);
         idle_all();
         if (is_inst) begin
            a = ((i / 2) % 2 == 1) ? 32'h0000_0104 : 32'h0000_0100;
            bus.inst_req  = 1'b1;
            bus.inst_addr = a;
         end else begin
            bus.data_req  = 1'b1;
            bus.data_addr = 32'h0000_0100;
         end
         @(negedge clock);
         total++;
         if (bus.inst_gnt !== is_inst || bus.data_gnt !== !is_inst || bus.mem_en !== 1'b1)
            $display("FAIL b2b_gnt[%0d] got inst=%b data=%b en=%b required inst=%b data=%b en=1", i, bus.inst_gnt, bus.data_gnt, bus.mem_en, is_inst, !is_inst);
         else passed++;
         if (is_inst) push_exp(1'b1, 1'b1, a[2] ? 64'h1122_3344 : 64'h5566_7788);
         else         push_exp(1'b0, 1'b1, 64'h1122_3344_5566_7788);
         tick();
      end
      idle_all();
      tick();
   endtask

   task automatic test_byte_wen();
      bus.data_req   = 1'b1;
      bus.data_wen   = 8'hFF;
      bus.data_addr  = 32'h0000_0108;
      bus.data_wdata = 64'h0;
      @(negedge clock);
      push_exp(1'b0, 1'b0, 64'h0);
      tick();
      bus.data_wen   = 8'h0F;
      bus.data_wdata = 64'hAAAA_AAAA_DEAD_BEEF;
      @(negedge clock);
      total++;
      if (bus.mem_wen !== 8'h0F || bus.mem_wdata !== 64'hAAAA_AAAA_DEAD_BEEF || bus.mem_addr !== 32'h108)
         $display("FAIL wen_fwd got wen=%h wdata=%h addr=%h required 0f/aaaaaaaadeadbeef/00000108", bus.mem_wen, bus.mem_wdata, bus.mem_addr);
      else passed++;
      push_exp(1'b0, 1'b0, 64'h0);
      tick();
      bus.data_wen   = 8'h00;
      bus.data_wdata = 64'h0;
      @(negedge clock);
      push_exp(1'b0, 1'b1, 64'h0000_0000_DEAD_BEEF);
      tick();
      idle_all();
      bus.inst_req  = 1'b1;
      bus.inst_addr = 32'h0000_010C;
      @(negedge clock);
      push_exp(1'b1, 1'b1, 64'h0);
      tick();
      bus.inst_addr = 32'h0000_0108;
      @(negedge clock);
      push_exp(1'b1, 1'b1, 64'hDEAD_BEEF);
      tick();
      idle_all();
      tick();
   endtask

   task automatic test_reset_mid();
      bus.inst_req  = 1'b1;
      bus.inst_addr = 32'h0000_0100;
      bus.data_req  = 1'b1;
      bus.data_wen  = 8'h00;
      bus.data_addr = 32'h0000_0100;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         push_exp(1'b0, 1'b1, 64'h1122_3344_5566_7788);
         tick();
      end
      @(negedge clock);
      total++;
      if (bus.data_gnt !== 1'b1) $display("FAIL rstmid_gnt got %b required 1", bus.data_gnt);
      else passed++;
      #1;
      reset_n = 1'b0;
      #1;
      total++;
      if (bus.mem_en !== 1'b0 || bus.data_gnt !== 1'b0 || bus.inst_gnt !== 1'b0)
         $display("FAIL rstmid_mem got en=%b dgnt=%b ignt=%b required 0/0/0", bus.mem_en, bus.data_gnt, bus.inst_gnt);
      else passed++;
      total++;
      if (dut.streak !== 4'd0) $display("FAIL rstmid_streak got %0d required 0", dut.streak);
      else passed++;
      @(negedge clock);
      total++;
      if (bus.data_rvalid !== 1'b0 || bus.inst_rvalid !== 1'b0)
         $display("FAIL rstmid_rvalid got data=%b inst=%b required 0/0", bus.data_rvalid, bus.inst_rvalid);
      else passed++;
      idle_all();
      tick();
      reset_n = 1'b1;
      tick();
      tick();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 64'h0;
      bus.mem_rdata = 64'h0;
      idle_all();
      test_reset();
      test_write_read();
      test_inst_lane();
      test_starvation();
      test_back_to_back();
      test_byte_wen();
      test_reset_mid();
      tick();
      total++;
      if (sb.size() != 0) $display("FAIL sb_drain got %0d pending required 0", sb.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1);
   end

endmodule
